// File: rtl/legv8_multicycle_core.sv
// legv8_multicycle_core: multi-cycle LEGv8 subset core (ADD/SUB/AND/ORR/LDUR/STUR/CBZ/B) on one shared memory port.
// Ports: clk, reset_n (async active-low); mem_req/mem_we/mem_addr/mem_wdata (registered request),
//        mem_rdata/mem_ready (completion); pc (instruction in flight), retired (completion pulse), halted.
// Build option: define LEGV8_ILLEGAL_TRAP_EN to halt on illegal opcodes; otherwise they retire as NOPs.
module legv8_multicycle_core #(
  parameter int                DATA_W   = 64,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc,
  output logic              retired,
  output logic              halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [DATA_W-1:0] FOUR = DATA_W'(4);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d, y_q, y_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rf_q [32];
  logic [DATA_W-1:0] rf_d [32];
  logic [31:0]       ir_q, ir_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              retired_q, retired_d, halted_q, halted_d;
  logic [10:0]       op;
  logic [4:0]        rn, rd, rm, b_sel;
  logic              is_add, is_sub, is_and, is_orr, is_alu, is_ldur, is_stur, is_cbz, is_b, done;
  logic [DATA_W-1:0] alu, imm_dt, imm_cb, imm_br;
  assign op      = ir_q[31:21];
  assign rn      = ir_q[9:5];
  assign rd      = ir_q[4:0];
  assign rm      = ir_q[20:16];
  assign is_add  = op == 11'b10001011000;
  assign is_sub  = op == 11'b11001011000;
  assign is_and  = op == 11'b10001010000;
  assign is_orr  = op == 11'b10101010000;
  assign is_ldur = op == 11'b11111000010;
  assign is_stur = op == 11'b11111000000;
  assign is_cbz  = ir_q[31:24] == 8'b10110100;
  assign is_b    = ir_q[31:26] == 6'b000101;
  assign is_alu  = is_add | is_sub | is_and | is_orr;
  // R-type reads Rm as the second operand; STUR/CBZ read Rt from the Rd field
  assign b_sel   = is_alu ? rm : rd;
  assign imm_dt  = {{(DATA_W-9){ir_q[20]}}, ir_q[20:12]};
  assign imm_cb  = {{(DATA_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
  assign imm_br  = {{(DATA_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
  assign alu     = is_add ? a_q + b_q : is_sub ? a_q - b_q : is_and ? a_q & b_q : a_q | b_q;
  assign done    = mem_req_q & mem_ready;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    y_d         = y_q;
    rf_d        = rf_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    retired_d   = 1'b0;
    halted_d    = halted_q;
    case (state_q)
      FETCH: begin
        if (done) begin
          ir_d    = mem_rdata[31:0];
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = (rn == 5'd31) ? '0 : rf_q[rn];
        b_d     = (b_sel == 5'd31) ? '0 : rf_q[b_sel];
        imm_d   = is_b ? imm_br : is_cbz ? imm_cb : imm_dt;
        state_d = EXEC;
      end
      EXEC: begin
        if (is_alu) begin
          y_d     = alu;
          state_d = WB;
        end else if (is_ldur || is_stur) begin
          mem_req_d   = 1'b1;
          mem_we_d    = is_stur;
          mem_addr_d  = a_q + imm_q;
          mem_wdata_d = b_q;
          state_d     = MEM;
        end else if (is_cbz || is_b) begin
          pc_d      = pc_q + ((is_b || b_q == '0) ? imm_q : FOUR);
          retired_d = 1'b1;
          state_d   = FETCH;
        end else begin
`ifdef LEGV8_ILLEGAL_TRAP_EN
          halted_d  = 1'b1;
          state_d   = HALT;
`else
          pc_d      = pc_q + FOUR;
          retired_d = 1'b1;
          state_d   = FETCH;
`endif
        end
      end
      MEM: begin
        if (!done) begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_q;
        end else if (mem_we_q) begin
          pc_d      = pc_q + FOUR;
          retired_d = 1'b1;
          state_d   = FETCH;
        end else begin
          y_d     = mem_rdata;
          state_d = WB;
        end
      end
      WB: begin
        if (rd != 5'd31) rf_d[rd] = y_q;
        pc_d      = pc_q + FOUR;
        retired_d = 1'b1;
        state_d   = FETCH;
      end
      default: ;
    endcase
    // a fetch request is raised on entry to FETCH and held while waiting, but never in the
    // cycle right after a completed access, so mem_req always drops between accesses
    if (state_d == FETCH && !done) begin
      mem_req_d  = 1'b1;
      mem_addr_d = pc_d;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      y_q         <= '0;
      rf_q        <= '{default: '0};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      retired_q   <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      y_q         <= y_d;
      rf_q        <= rf_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      retired_q   <= retired_d;
      halted_q    <= halted_d;
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign retired   = retired_q;
  assign halted    = halted_q;
endmodule

// File: tb/tb_legv8_multicycle_core.sv
// tb_legv8_multicycle_core: table-driven and scoreboard bench for legv8_multicycle_core.
module tb_legv8_multicycle_core;
  localparam logic [10:0] ADD = 11'b10001011000, SUB = 11'b11001011000;
  localparam logic [10:0] AND = 11'b10001010000, ORR = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010, STUR = 11'b11111000000;
  logic        clk = 1'b0, reset_n = 1'b1, mem_ready = 1'b0;
  logic        mem_req, mem_we, retired, halted;
  logic [63:0] mem_addr, mem_wdata, pc, mem_rdata = '0;
  typedef struct {logic [63:0] a, d;} wr_t;
  typedef struct {string name; logic [10:0] op; logic [63:0] a, b, y;} vec_t;
  logic [63:0] mem [1024];
  logic [63:0] exp_pc [$];
  wr_t         exp_wr [$];
  wr_t         w;
  vec_t        v [6];
  int          rt [$];
  int          n_vec = 0, n_bad = 0, wait_cfg = 0, wait_cnt = 0;
  logic        hold_v = 1'b0, h_we = 1'b0;
  logic [63:0] h_addr = '0, h_wdata = '0;
  always #5 clk = ~clk;
  legv8_multicycle_core #(.DATA_W(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .retired(retired), .halted(halted));
  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] r_i(logic [10:0] o, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm);
    return {o, rm, 6'd0, rn, rd};
  endfunction
  function automatic logic [31:0] d_i(logic [10:0] o, logic [4:0] rt_, logic [4:0] rn, logic [8:0] imm);
    return {o, imm, 2'b00, rn, rt_};
  endfunction
  function automatic logic [31:0] cbz_i(logic [4:0] rt_, logic [18:0] imm);
    return {8'hB4, imm, rt_};
  endfunction
  function automatic logic [31:0] b_i(logic [25:0] imm);
    return {6'b000101, imm};
  endfunction
  function automatic int rt_at(int k);
    return (rt.size() > k) ? rt[k] : -1;
  endfunction
  task automatic put(int a, logic [63:0] d);
    mem[a / 4] = d;
  endtask
  task automatic hold_reset(int wc);
    reset_n = 1'b0;
    exp_pc.delete();
    exp_wr.delete();
    wait_cfg = wc;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    @(negedge clk);
  endtask
  task automatic release_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic drain(string nm, int budget);
    int n = 0;
    rt.delete();
    while ((exp_pc.size() + exp_wr.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (retired) rt.push_back(n);
    end
    check({nm, "_drain"}, 64'(exp_pc.size() + exp_wr.size()), 64'd0);
  endtask
  task automatic check_reset_outputs(string nm);
    check({nm, "_req"}, 64'(mem_req), 64'd0);
    check({nm, "_we"}, 64'(mem_we), 64'd0);
    check({nm, "_addr"}, mem_addr, 64'd0);
    check({nm, "_wdata"}, mem_wdata, 64'd0);
    check({nm, "_pc"}, pc, 64'd0);
    check({nm, "_retired"}, 64'(retired), 64'd0);
    check({nm, "_halted"}, 64'(halted), 64'd0);
  endtask
  // memory model with configurable wait states, plus stability check of a pending request
  always @(negedge clk) begin
    if (!reset_n) hold_v = 1'b0;
    else if (hold_v) begin
      check("hold_req_we", {62'd0, mem_req, mem_we}, {62'd0, 1'b1, h_we});
      check("hold_addr", mem_addr, h_addr);
      check("hold_wdata", mem_wdata, h_wdata);
    end
    if (mem_req && wait_cnt >= wait_cfg) begin
      mem_ready = 1'b1;
      mem_rdata = mem[mem_addr[11:2]];
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = mem_req ? wait_cnt + 1 : 0;
    end
    hold_v  = reset_n && mem_req && !mem_ready;
    h_we    = mem_we;
    h_addr  = mem_addr;
    h_wdata = mem_wdata;
  end
  always @(negedge clk)
    if (reset_n && retired && exp_pc.size() != 0) check("retire_pc", pc, exp_pc.pop_front());
  always @(posedge clk)
    if (reset_n && mem_req && mem_ready && mem_we) begin
      mem[mem_addr[11:2]] = mem_wdata;
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        check("wr_addr", mem_addr, w.a);
        check("wr_data", mem_wdata, w.d);
      end else begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_wr: addr %0h data %0h, no write expected", mem_addr, mem_wdata);
      end
    end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc, req_cyc;
    v[0] = '{"add", ADD, 64'd5, 64'd7, 64'd12};
    v[1] = '{"sub_wrap", SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
    v[2] = '{"and", AND, 64'hF0F0, 64'hFF00, 64'hF000};
    v[3] = '{"orr", ORR, 64'hF0F0, 64'h0F0F, 64'hFFFF};
    v[4] = '{"add_wrap", ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    v[5] = '{"sub", SUB, 64'h100, 64'h1, 64'hFF};
    // reset values and first-instruction latency
    #1;
    hold_reset(0);
    check_reset_outputs("rst");
    put(0, r_i(ADD, 3, 1, 2));
    put(4, b_i(26'd0));
    release_reset();
    cyc = 0;
    req_cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (mem_req && req_cyc == 0) req_cyc = cyc;
    end while (!retired && cyc < 20);
    check("first_req_cycle", 64'(req_cyc), 64'd1);
    check("add_retire_cycle", 64'(cyc), 64'd5);
    check("add_pc", pc, 64'd4);
    // ALU vectors: load operands, operate, store the result
    for (int i = 0; i < 6; i++) begin
      hold_reset(i % 3);
      put(0, d_i(LDUR, 1, 31, 9'h80));
      put(4, d_i(LDUR, 2, 31, 9'h88));
      put(8, r_i(v[i].op, 3, 1, 2));
      put(12, d_i(STUR, 3, 31, 9'h90));
      put(16, b_i(26'd0));
      put(32'h80, v[i].a);
      put(32'h88, v[i].b);
      exp_pc = '{64'h4, 64'h8, 64'hC, 64'h10};
      exp_wr.push_back('{64'h90, v[i].y});
      release_reset();
      drain(v[i].name, 400);
      check({v[i].name, "_ldur_cycles"}, 64'(rt_at(1) - rt_at(0)), 64'(5 + 2 * wait_cfg));
      check({v[i].name, "_alu_cycles"}, 64'(rt_at(2) - rt_at(1)), 64'(4 + wait_cfg));
      check({v[i].name, "_stur_cycles"}, 64'(rt_at(3) - rt_at(2)), 64'(4 + 2 * wait_cfg));
    end
    // X0 cleared by SUB, X31 write discarded
    hold_reset(1);
    put(0, d_i(LDUR, 1, 31, 9'h80));
    put(4, d_i(LDUR, 0, 31, 9'h80));
    put(8, r_i(SUB, 0, 0, 0));
    put(12, r_i(ORR, 31, 1, 1));
    put(16, d_i(STUR, 0, 31, 9'h90));
    put(20, d_i(STUR, 31, 31, 9'h98));
    put(24, b_i(26'd0));
    put(32'h80, 64'h55AA);
    exp_pc = '{64'h4, 64'h8, 64'hC, 64'h10, 64'h14, 64'h18};
    exp_wr = '{'{64'h90, 64'h0}, '{64'h98, 64'h0}};
    release_reset();
    drain("x0_x31", 600);
    // store with wait states, then load it back
    hold_reset(3);
    put(0, d_i(LDUR, 1, 31, 9'h80));
    put(4, d_i(LDUR, 2, 31, 9'h88));
    put(8, d_i(STUR, 2, 1, 9'h8));
    put(12, d_i(LDUR, 4, 1, 9'h8));
    put(16, d_i(STUR, 4, 31, 9'h90));
    put(20, b_i(26'd0));
    put(32'h80, 64'h100);
    put(32'h88, 64'hDEAD);
    exp_pc = '{64'h4, 64'h8, 64'hC, 64'h10, 64'h14};
    exp_wr = '{'{64'h108, 64'hDEAD}, '{64'h90, 64'hDEAD}};
    release_reset();
    drain("stur_wait", 800);
    // a store to the next instruction is seen by its fetch
    hold_reset(0);
    put(0, d_i(LDUR, 1, 31, 9'h80));
    put(4, d_i(STUR, 1, 31, 9'h8));
    put(8, b_i(26'd0));
    put(16, b_i(26'd0));
    put(32'h80, {32'd0, b_i(26'd2)});
    exp_pc = '{64'h4, 64'h8, 64'h10};
    exp_wr.push_back('{64'h8, {32'd0, b_i(26'd2)}});
    release_reset();
    drain("self_modify", 400);
    // CBZ taken and not taken
    for (int x = 0; x < 2; x++) begin
      hold_reset(0);
      put(0, d_i(LDUR, 5, 31, 9'h80));
      put(4, b_i(26'd7));
      put(32'h18, b_i(26'd0));
      put(32'h20, cbz_i(5, 19'h7FFFE));
      put(32'h24, b_i(26'd0));
      put(32'h80, 64'(x));
      exp_pc = '{64'h4, 64'h20, (x == 0) ? 64'h18 : 64'h24};
      release_reset();
      drain((x == 0) ? "cbz_taken" : "cbz_not_taken", 400);
      check("b_cycles", 64'(rt_at(1) - rt_at(0)), 64'd3);
      check("cbz_cycles", 64'(rt_at(2) - rt_at(1)), 64'd3);
    end
    // backward branch wraps below zero
    hold_reset(0);
    put(0, b_i(26'h3FFFFFF));
    exp_pc.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    release_reset();
    drain("b_wrap", 100);
    check("b_first_retire_cycle", 64'(rt_at(0)), 64'd4);
    // illegal opcode at 0x10
    hold_reset(0);
    put(0, b_i(26'd4));
    put(32'h10, 64'hFFFF_FFFF);
    put(32'h14, b_i(26'd0));
    exp_pc.push_back(64'h10);
`ifdef LEGV8_ILLEGAL_TRAP_EN
    release_reset();
    drain("illegal_trap", 100);
    cyc = 0;
    while (!halted && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("trap_halted", 64'(halted), 64'd1);
    check("trap_pc", pc, 64'h10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("trap_req", 64'(mem_req), 64'd0);
      check("trap_retired", 64'(retired), 64'd0);
    end
`else
    exp_pc.push_back(64'h14);
    release_reset();
    drain("illegal_nop", 100);
    check("nop_cycles", 64'(rt_at(1) - rt_at(0)), 64'd3);
    check("nop_halted", 64'(halted), 64'd0);
`endif
    // reset while a store is waiting in MEM
    hold_reset(40);
    put(0, d_i(LDUR, 2, 31, 9'h88));
    put(4, d_i(STUR, 2, 31, 9'h90));
    put(32'h88, 64'hDEAD);
    exp_pc.push_back(64'h4);
    release_reset();
    cyc = 0;
    while (!(mem_req && mem_we) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_store_pending", {62'd0, mem_req, mem_we}, 64'd3);
    check("mid_store_wdata", mem_wdata, 64'hDEAD);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_pc.delete();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    put(0, d_i(STUR, 2, 31, 9'h98));
    put(4, b_i(26'd0));
    wait_cfg = 0;
    exp_pc.push_back(64'h4);
    exp_wr.push_back('{64'h98, 64'h0});
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("restart_req", 64'(mem_req), 64'd1);
    check("restart_addr", mem_addr, 64'd0);
    drain("restart", 100);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
